// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table,
// blank cathode pattern and cathode bit positions.
package seg_pkg;

  // Cathode bit positions (a..g, then the decimal point)
  localparam int SEG_A_BIT  = 0;
  localparam int SEG_G_BIT  = 6;
  localparam int SEG_DP_BIT = 7;

  // All cathodes high = every segment dark (common-anode display)
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-high a..g patterns for hex 0..F (b and d lowercase)
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational hex nibble to active-high a..g segment pattern.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] segs
);

  // Table lookup of the glyph for the selected nibble
  always_comb begin
    segs = GLYPH_TABLE[code];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with per-digit blank, dp,
// blink and PWM brightness. Inputs are captured once per frame so a
// value change never tears across a partially drawn frame.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SLOT_LOG2  = 14,
  parameter int BRIGHT_W   = 3,
  parameter int BLINK_LOG2 = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              cathode
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [SLOT_LOG2-1:0]    pre_r;
  logic [IDX_W-1:0]        idx_r;
  logic [BLINK_LOG2-1:0]   frame_r;
  logic [4*NUM_DIGITS-1:0] digits_sh_r;
  logic [NUM_DIGITS-1:0]   en_sh_r;
  logic [NUM_DIGITS-1:0]   dp_sh_r;
  logic [NUM_DIGITS-1:0]   blink_sh_r;
  logic [BRIGHT_W-1:0]     bright_sh_r;

  logic                    slot_end_s;
  logic                    frame_end_s;
  logic                    blink_phase_s;
  logic                    lit_s;
  logic [3:0]              nibble_s;
  logic [6:0]              glyph_s;
  logic [NUM_DIGITS-1:0]   anode_s;
  logic [7:0]              cathode_s;

  assign slot_end_s    = &pre_r;
  assign frame_end_s   = slot_end_s && (idx_r == LAST_IDX);
  assign blink_phase_s = frame_r[BLINK_LOG2-1];
  assign nibble_s      = digits_sh_r[{idx_r, 2'b00} +: 4];

  seg_glyph_decode u_glyph (
    .code (nibble_s),
    .segs (glyph_s)
  );

  // Prescaler, digit index, frame counter and frame-end shadow capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_r       <= {SLOT_LOG2{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      frame_r     <= {BLINK_LOG2{1'b0}};
      digits_sh_r <= {(4*NUM_DIGITS){1'b0}};
      en_sh_r     <= {NUM_DIGITS{1'b0}};
      dp_sh_r     <= {NUM_DIGITS{1'b0}};
      blink_sh_r  <= {NUM_DIGITS{1'b0}};
      bright_sh_r <= {BRIGHT_W{1'b0}};
    end else begin
      pre_r <= pre_r + SLOT_LOG2'(1);
      if (slot_end_s) begin
        if (frame_end_s) begin
          idx_r <= {IDX_W{1'b0}};
        end else begin
          idx_r <= idx_r + IDX_W'(1);
        end
      end
      if (frame_end_s) begin
        frame_r     <= frame_r + BLINK_LOG2'(1);
        digits_sh_r <= digits;
        en_sh_r     <= digit_en;
        dp_sh_r     <= dp_en;
        blink_sh_r  <= blink_mask;
        bright_sh_r <= brightness;
      end
    end
  end

  // Lit decision: enabled, not in blink-off phase, past the dead cycle, within PWM duty
  always_comb begin
    lit_s = 1'b0;
    if (en_sh_r[idx_r] &&
        !(blink_sh_r[idx_r] && blink_phase_s) &&
        (pre_r != {SLOT_LOG2{1'b0}}) &&
        (pre_r[SLOT_LOG2-1 -: BRIGHT_W] <= bright_sh_r)) begin
      lit_s = 1'b1;
    end else begin
      lit_s = 1'b0;
    end
  end

  // Next anode/cathode pattern; dark means every pin high
  always_comb begin
    anode_s   = {NUM_DIGITS{1'b1}};
    cathode_s = SEG_OFF;
    if (lit_s) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        anode_s[i] = (idx_r != IDX_W'(i));
      end
      cathode_s[SEG_G_BIT:SEG_A_BIT] = ~glyph_s;
      cathode_s[SEG_DP_BIT]          = ~dp_sh_r[idx_r];
    end else begin
      anode_s   = {NUM_DIGITS{1'b1}};
      cathode_s = SEG_OFF;
    end
  end

  // Output registers so anode and cathode switch on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anode   <= {NUM_DIGITS{1'b1}};
      cathode <= SEG_OFF;
    end else begin
      anode   <= anode_s;
      cathode <= cathode_s;
    end
  end

endmodule
